tvm_stream_ram: RTL and testbench

- Synthesizable, parametrised successor to the VPI-backed RAM shim. Same control/stream interface, but storage and transfer logic are real RTL.
- Contains an internal dual-port word memory, a read engine that streams bursts into a read FIFO, and a write engine that drains a write FIFO into memory.
- Sits between accelerator datapaths and an on-chip buffer. Used where simulation must run without the VPI host, and in FPGA builds.

---
 rtl/tvm_stream_ram.sv | 125 ++++++++++++
 tb/tb_tvm_stream_ram.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tvm_stream_ram.sv
// tvm_stream_ram: word RAM with a burst read engine feeding a read FIFO and a write engine draining a write FIFO
module tvm_stream_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_read_req,
  input  logic [31:0]           ctrl_read_addr,
  input  logic [31:0]           ctrl_read_size,
  input  logic                  ctrl_write_req,
  input  logic [31:0]           ctrl_write_addr,
  input  logic [31:0]           ctrl_write_size,
  input  logic                  in_read_dequeue,
  input  logic                  in_write_enable,
  input  logic [DATA_WIDTH-1:0] in_write_data,
  output logic [DATA_WIDTH-1:0] out_read_data,
  output logic                  out_read_valid,
  output logic                  out_write_full,
  output logic                  out_read_busy,
  output logic                  out_write_busy,
  output logic                  out_req_error
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} r_state_t;
  typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  inflight;
  r_state_t              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_left;
  logic [DATA_WIDTH-1:0] rf_mem [FIFO_DEPTH];
  logic [PW-1:0]         rf_wp, rf_rp;
  logic [CW-1:0]         rf_count;
  w_state_t              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [31:0]           w_acc, w_left;
  logic [DATA_WIDTH-1:0] wf_mem [FIFO_DEPTH];
  logic [PW-1:0]         wf_wp, wf_rp;
  logic [CW-1:0]         wf_count;
  logic                  rd_start, rd_space, issue, rf_deq, wr_start, push, pop;
  logic [ADDR_WIDTH-1:0] iss_addr;
  // the first read of a burst is issued in the request cycle itself to save a cycle of latency
  always_comb begin
    rd_start       = r_state == R_IDLE && ctrl_read_req && ctrl_read_size != 32'd0;
    rd_space       = 32'(rf_count) + 32'(inflight) < 32'(FIFO_DEPTH);
    issue          = (rd_start || r_state == R_ISSUE) && rd_space;
    iss_addr       = r_state == R_IDLE ? ctrl_read_addr[ADDR_WIDTH-1:0] : r_addr;
    rf_deq         = in_read_dequeue && rf_count != '0;
    wr_start       = w_state == W_IDLE && ctrl_write_req && ctrl_write_size != 32'd0;
    out_write_full = !(w_state == W_ACTIVE && w_acc != 32'd0 && 32'(wf_count) < 32'(FIFO_DEPTH));
    push           = in_write_enable && !out_write_full;
    pop            = wf_count != '0;
    out_read_valid = rf_count != '0;
    out_read_data  = out_read_valid ? rf_mem[rf_rp] : '0;
    out_read_busy  = r_state != R_IDLE;
    out_write_busy = w_state != W_IDLE;
  end
  always_ff @(posedge clk) begin
    if (issue) rd_q <= mem[iss_addr];
    if (pop) mem[w_addr] <= wf_mem[wf_rp];
    if (inflight) rf_mem[rf_wp] <= rd_q;
    if (push) wf_mem[wf_wp] <= in_write_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      r_addr        <= '0;
      r_left        <= '0;
      inflight      <= 1'b0;
      rf_wp         <= '0;
      rf_rp         <= '0;
      rf_count      <= '0;
      out_req_error <= 1'b0;
    end else begin
      inflight      <= issue;
      rf_wp         <= rf_wp + PW'(inflight);
      rf_rp         <= rf_rp + PW'(rf_deq);
      rf_count      <= rf_count + CW'(inflight) - CW'(rf_deq);
      out_req_error <= (ctrl_read_req && r_state != R_IDLE) || (ctrl_write_req && w_state != W_IDLE);
      if (rd_start) begin
        r_addr  <= iss_addr + ADDR_WIDTH'(issue);
        r_left  <= ctrl_read_size - 32'(issue);
        r_state <= issue && ctrl_read_size == 32'd1 ? R_DRAIN : R_ISSUE;
      end else if (r_state == R_ISSUE && issue) begin
        r_addr  <= r_addr + 1'b1;
        r_left  <= r_left - 32'd1;
        r_state <= r_left == 32'd1 ? R_DRAIN : R_ISSUE;
      end else if (r_state == R_DRAIN && inflight) begin
        r_state <= R_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state  <= W_IDLE;
      w_addr   <= '0;
      w_acc    <= '0;
      w_left   <= '0;
      wf_wp    <= '0;
      wf_rp    <= '0;
      wf_count <= '0;
    end else begin
      wf_wp    <= wf_wp + PW'(push);
      wf_rp    <= wf_rp + PW'(pop);
      wf_count <= wf_count + CW'(push) - CW'(pop);
      if (wr_start) begin
        w_state <= W_ACTIVE;
        w_addr  <= ctrl_write_addr[ADDR_WIDTH-1:0];
        w_acc   <= ctrl_write_size;
        w_left  <= ctrl_write_size;
      end else if (w_state == W_ACTIVE) begin
        w_acc <= w_acc - 32'(push);
        if (pop) begin
          w_addr  <= w_addr + 1'b1;
          w_left  <= w_left - 32'd1;
          w_state <= w_left == 32'd1 ? W_IDLE : W_ACTIVE;
        end
      end
    end
  end
endmodule

// File: tb/tb_tvm_stream_ram.sv
// tb_tvm_stream_ram: cycle table for write/read/error basics plus directed wrap, stall and reset sequences
module tb_tvm_stream_ram;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ctrl_read_req = 1'b0, ctrl_write_req = 1'b0;
  logic [31:0] ctrl_read_addr = '0, ctrl_read_size = '0, ctrl_write_addr = '0, ctrl_write_size = '0;
  logic        in_read_dequeue = 1'b0, in_write_enable = 1'b0;
  logic [7:0]  in_write_data = '0;
  logic [7:0]  out_read_data;
  logic        out_read_valid, out_write_full, out_read_busy, out_write_busy, out_req_error;
  int          pass_cnt = 0, total_cnt = 0;
  logic [7:0]  exp_q [$];

  tvm_stream_ram dut (
    .clk(clk), .rst(rst),
    .ctrl_read_req(ctrl_read_req), .ctrl_read_addr(ctrl_read_addr), .ctrl_read_size(ctrl_read_size),
    .ctrl_write_req(ctrl_write_req), .ctrl_write_addr(ctrl_write_addr), .ctrl_write_size(ctrl_write_size),
    .in_read_dequeue(in_read_dequeue), .in_write_enable(in_write_enable), .in_write_data(in_write_data),
    .out_read_data(out_read_data), .out_read_valid(out_read_valid), .out_write_full(out_write_full),
    .out_read_busy(out_read_busy), .out_write_busy(out_write_busy), .out_req_error(out_req_error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic rq; logic [31:0] ra, rs;
    logic wq; logic [31:0] wa, ws;
    logic dq, we; logic [7:0] wd;
    logic ev; logic [7:0] ed; logic ef, erb, ewb, ee;
  } vec_t;

  function automatic vec_t v(logic rq, logic [31:0] ra, logic [31:0] rs, logic wq, logic [31:0] wa,
                             logic [31:0] ws, logic dq, logic we, logic [7:0] wd, logic ev,
                             logic [7:0] ed, logic ef, logic erb, logic ewb, logic ee);
    v = '{rq, ra, rs, wq, wa, ws, dq, we, wd, ev, ed, ef, erb, ewb, ee};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [31:0] n, input logic [7:0] base);
    int t;
    ctrl_write_req = 1'b1; ctrl_write_addr = a; ctrl_write_size = n;
    step();
    ctrl_write_req = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      t = 0;
      while (out_write_full && t < 20) begin step(); t++; end
      in_write_enable = 1'b1; in_write_data = base + 8'(i);
      step();
      in_write_enable = 1'b0;
    end
    t = 0;
    while (out_write_busy && t < 20) begin step(); t++; end
    chk("wr_done", {31'd0, out_write_busy}, 32'd0);
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] n, input int hold);
    int got, t;
    ctrl_read_req = 1'b1; ctrl_read_addr = a; ctrl_read_size = n;
    step();
    ctrl_read_req = 1'b0;
    for (int k = 0; k < hold; k++) step();
    if (hold > 0) begin
      chk({name, "_stall_cnt"}, 32'(dut.rf_count), 32'd4);
      chk({name, "_stall_busy"}, {31'd0, out_read_busy}, 32'd1);
    end
    in_read_dequeue = 1'b1;
    got = 0; t = 0;
    while (got < int'(n) && t < 200) begin
      if (out_read_valid) begin
        chk({name, "_data"}, {24'd0, out_read_data}, {24'd0, exp_q[got]});
        got++;
      end
      step(); t++;
    end
    chk({name, "_count"}, 32'(got), n);
    step(); step();
    in_read_dequeue = 1'b0;
    chk({name, "_busy_end"}, {31'd0, out_read_busy}, 32'd0);
    chk({name, "_valid_end"}, {31'd0, out_read_valid}, 32'd0);
  endtask

  vec_t tbl [14];

  initial begin
    tbl[0]  = v(0, 0, 0,   1, 5, 4,   0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0);
    tbl[1]  = v(0, 0, 0,   0, 0, 0,   0, 1, 8'hA0, 0, 8'h00, 0, 0, 1, 0);
    tbl[2]  = v(0, 0, 0,   1, 200, 3, 0, 1, 8'hA1, 0, 8'h00, 0, 0, 1, 1);
    tbl[3]  = v(0, 0, 0,   0, 0, 0,   0, 1, 8'hA2, 0, 8'h00, 0, 0, 1, 0);
    tbl[4]  = v(0, 0, 0,   0, 0, 0,   0, 1, 8'hA3, 0, 8'h00, 1, 0, 1, 0);
    tbl[5]  = v(0, 0, 0,   0, 0, 0,   0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    tbl[6]  = v(1, 5, 4,   0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 1, 1, 0, 0);
    tbl[7]  = v(0, 0, 0,   0, 0, 0,   1, 0, 8'h00, 1, 8'hA0, 1, 1, 0, 0);
    tbl[8]  = v(1, 100, 9, 0, 0, 0,   1, 0, 8'h00, 1, 8'hA1, 1, 1, 0, 1);
    tbl[9]  = v(0, 0, 0,   0, 0, 0,   1, 0, 8'h00, 1, 8'hA2, 1, 1, 0, 0);
    tbl[10] = v(0, 0, 0,   0, 0, 0,   1, 0, 8'h00, 1, 8'hA3, 1, 0, 0, 0);
    tbl[11] = v(0, 0, 0,   0, 0, 0,   1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    tbl[12] = v(0, 0, 0,   1, 0, 0,   0, 1, 8'hFF, 0, 8'h00, 1, 0, 0, 0);
    tbl[13] = v(0, 0, 0,   0, 0, 0,   0, 1, 8'hEE, 0, 8'h00, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, out_read_valid}, 32'd0);
    chk("rst_data", {24'd0, out_read_data}, 32'd0);
    chk("rst_full", {31'd0, out_write_full}, 32'd1);
    chk("rst_rbusy", {31'd0, out_read_busy}, 32'd0);
    chk("rst_wbusy", {31'd0, out_write_busy}, 32'd0);
    chk("rst_err", {31'd0, out_req_error}, 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      ctrl_read_req = tbl[i].rq; ctrl_read_addr = tbl[i].ra; ctrl_read_size = tbl[i].rs;
      ctrl_write_req = tbl[i].wq; ctrl_write_addr = tbl[i].wa; ctrl_write_size = tbl[i].ws;
      in_read_dequeue = tbl[i].dq; in_write_enable = tbl[i].we; in_write_data = tbl[i].wd;
      step();
      chk($sformatf("row%0d_valid", i), {31'd0, out_read_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("row%0d_data", i), {24'd0, out_read_data}, {24'd0, tbl[i].ed});
      chk($sformatf("row%0d_full", i), {31'd0, out_write_full}, {31'd0, tbl[i].ef});
      chk($sformatf("row%0d_rbusy", i), {31'd0, out_read_busy}, {31'd0, tbl[i].erb});
      chk($sformatf("row%0d_wbusy", i), {31'd0, out_write_busy}, {31'd0, tbl[i].ewb});
      chk($sformatf("row%0d_err", i), {31'd0, out_req_error}, {31'd0, tbl[i].ee});
    end
    ctrl_read_req = 1'b0; ctrl_write_req = 1'b0; in_read_dequeue = 1'b0; in_write_enable = 1'b0;
    step();

    write_burst(1022, 4, 8'h10);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    read_check("wrap", 1022, 4, 0);
    exp_q = '{8'h12, 8'h13};
    read_check("wrap_low", 0, 2, 0);

    write_burst(9, 4, 8'hB0);
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    read_check("stall", 5, 8, 6);

    ctrl_read_req = 1'b1; ctrl_read_addr = 5; ctrl_read_size = 8;
    step();
    ctrl_read_req = 1'b0;
    step(); step();
    chk("pre_rst_cnt", 32'(dut.rf_count), 32'd2);
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_read_valid}, 32'd0);
    chk("arst_data", {24'd0, out_read_data}, 32'd0);
    chk("arst_rbusy", {31'd0, out_read_busy}, 32'd0);
    chk("arst_full", {31'd0, out_write_full}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("post_rst_valid", {31'd0, out_read_valid}, 32'd0);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    read_check("fresh", 1022, 4, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
